// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-port AXI4 read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way pick between the fetch (0) and load (1) requesters.
// Build option: define ARB_RR_EN for round-robin ties; otherwise port 1 wins ties.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_winner
);

`ifdef ARB_RR_EN
    // A lone requester wins; on a tie the port that did not win last time goes
    always_comb begin
        if (&i_req) begin
            o_winner = ~i_last_grant;
        end else begin
            o_winner = i_req[1];
        end
    end
`else
    // Fixed priority needs neither the history nor the port 0 request bit
    logic w_unused_inputs;
    assign w_unused_inputs = i_last_grant ^ i_req[0];

    // Port 1 wins whenever it asks; port 0 wins only when alone
    always_comb begin
        o_winner = i_req[1];
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between instruction fetch (s0) and data load (s1).
// Only one burst is outstanding; the grant is held from AR acceptance until RLAST.
// Build option: ARB_RR_EN selects round-robin tie-breaking inside rr_arb2.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // Requester 0: instruction fetch
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    input  logic [ADDR_W-1:0]     s0_araddr,
    input  logic [AXI_LEN_W-1:0]  s0_arlen,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    output logic [DATA_W-1:0]     s0_rdata,
    output logic [AXI_RESP_W-1:0] s0_rresp,
    output logic                  s0_rlast,
    // Requester 1: data load
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    input  logic [ADDR_W-1:0]     s1_araddr,
    input  logic [AXI_LEN_W-1:0]  s1_arlen,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [DATA_W-1:0]     s1_rdata,
    output logic [AXI_RESP_W-1:0] s1_rresp,
    output logic                  s1_rlast,
    // Master AR
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [AXI_LEN_W-1:0]  m_arlen,
    output logic [ID_W-1:0]       m_arid,
    // Master R
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [AXI_RESP_W-1:0] m_rresp,
    input  logic                  m_rlast,
    input  logic [ID_W-1:0]       m_rid
);

    arb_state_e r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       w_winner;
    logic [1:0] w_req;
    logic       w_ar_hs;
    logic       w_r_done;

    // With a single outstanding burst the returning ID always matches the grant
    logic w_unused_rid;
    assign w_unused_rid = ^m_rid;

    assign w_req    = {s1_arvalid, s0_arvalid};
    assign w_ar_hs  = m_arvalid & m_arready;
    assign w_r_done = m_rvalid & m_rready & m_rlast;

    rr_arb2 u_rr_arb2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    // Grant FSM: pick in IDLE, hold through AR handshake and the whole burst
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_winner;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) begin
                        r_last_grant <= r_grant;
                        r_state      <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_done) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Route AR from the granted requester and R back to it; everything else idles at zero
    always_comb begin
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arid     = '0;
        m_rready   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        s0_rdata   = '0;
        s1_rdata   = '0;
        s0_rresp   = RESP_OKAY;
        s1_rresp   = RESP_OKAY;
        s0_rlast   = 1'b0;
        s1_rlast   = 1'b0;
        case (r_state)
            ADDR: begin
                m_arid = ID_W'(r_grant);
                if (r_grant) begin
                    m_arvalid  = s1_arvalid;
                    m_araddr   = s1_araddr;
                    m_arlen    = s1_arlen;
                    s1_arready = m_arready;
                end else begin
                    m_arvalid  = s0_arvalid;
                    m_araddr   = s0_araddr;
                    m_arlen    = s0_arlen;
                    s0_arready = m_arready;
                end
            end
            DATA: begin
                if (r_grant) begin
                    m_rready  = s1_rready;
                    s1_rvalid = m_rvalid;
                    s1_rdata  = m_rdata;
                    s1_rresp  = m_rresp;
                    s1_rlast  = m_rlast;
                end else begin
                    m_rready  = s0_rready;
                    s0_rvalid = m_rvalid;
                    s0_rdata  = m_rdata;
                    s0_rresp  = m_rresp;
                    s0_rlast  = m_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule
